gb_timer: RTL

//   DIV/TIMA/TMA/TAC timer block (0xFF04-0xFF07).

---
 rtl/gb_io_pkg.sv | 16 +
 rtl/timer_tap_edge.sv | 29 ++
 rtl/gb_timer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/gb_io_pkg.sv
// Shared I/O-block types: timer register selects, timer sequencer states and
// the TAC input-clock tap table.
package gb_io_pkg;

  typedef enum logic [1:0] {TIMER_DIV, TIMER_TIMA, TIMER_TMA, TIMER_TAC} timer_reg_t;

  typedef enum logic [1:0] {TIM_RUN, TIM_OVF, TIM_RELOAD} timer_state_t;

  // System-counter bit watched by TIMA for each TAC[1:0] clock select.
  localparam int TAC_TAP [4] = '{9, 3, 5, 7};

  function automatic logic [3:0] tac_tap_bit(input logic [1:0] sel);
    return 4'(TAC_TAP[sel]);
  endfunction

endpackage

// File: rtl/timer_tap_edge.sv
// TIMA clock detector: selects the TAC tap of the (post-update) system counter,
// gates it with the enable bit and flags a 1->0 transition on the current tick.
module timer_tap_edge
  import gb_io_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [15:0] counter,
  input  logic [2:0]  tac,
  output logic        fall
);

  logic s_now;
  logic s_prev;

  // Fed with next-state counter/TAC so DIV resets and TAC writes produce edges.
  assign s_now = tac[2] & counter[tac_tap_bit(tac[1:0])];
  assign fall  = tick & s_prev & ~s_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      s_prev <= 1'b0;
    end else if (tick) begin
      s_prev <= s_now;
    end
  end

endmodule

// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer: 16-bit system counter, TIMA overflow/reload
// sequencer, timer interrupt pulse and the APU frame-sequencer DIV tap.
module gb_timer
  import gb_io_pkg::*;
#(
  parameter int RELOAD_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       double_speed,
  input  logic       target,
  input  logic [1:0] reg_select,
  input  logic       write,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       irq,
  output logic       apu_div_bit
);

  localparam int CW = (RELOAD_DELAY > 1) ? $clog2(RELOAD_DELAY) : 1;

  timer_reg_t   sel;
  timer_state_t state;
  logic [15:0]  counter;
  logic [15:0]  counter_next;
  logic [7:0]   tima;
  logic [7:0]   tma;
  logic [7:0]   tma_next;
  logic [7:0]   reload_base;
  logic [2:0]   tac;
  logic [2:0]   tac_next;
  logic [CW-1:0] cnt;
  logic         wr;
  logic         wr_div;
  logic         wr_tima;
  logic         wr_tma;
  logic         wr_tac;
  logic         tap_fall;

  assign sel     = timer_reg_t'(reg_select);
  assign wr      = write & target & tick;
  assign wr_div  = wr & (sel == TIMER_DIV);
  assign wr_tima = wr & (sel == TIMER_TIMA);
  assign wr_tma  = wr & (sel == TIMER_TMA);
  assign wr_tac  = wr & (sel == TIMER_TAC);

  always_comb begin
    counter_next = wr_div ? 16'h0000 : counter + 16'd1;
    tac_next     = wr_tac ? wdata[2:0] : tac;
    tma_next     = wr_tma ? wdata : tma;
    // In RELOAD a TMA write lands in TIMA too; any tap edge then counts on top.
    reload_base  = wr_tma ? wdata : tima;
  end

  timer_tap_edge u_tap_edge (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .counter (counter_next),
    .tac     (tac_next),
    .fall    (tap_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= 16'h0000;
      tima    <= 8'h00;
      tma     <= 8'h00;
      tac     <= 3'b000;
      cnt     <= '0;
      irq     <= 1'b0;
      state   <= TIM_RUN;
    end else if (tick) begin
      counter <= counter_next;
      tac     <= tac_next;
      tma     <= tma_next;
      irq     <= 1'b0;
      case (state)
        TIM_RUN: begin
          if (wr_tima) begin
            tima <= wdata;
          end else if (tap_fall) begin
            if (tima == 8'hFF) begin
              tima  <= 8'h00;
              cnt   <= CW'(RELOAD_DELAY - 1);
              state <= TIM_OVF;
            end else begin
              tima <= tima + 8'd1;
            end
          end
        end
        TIM_OVF: begin
          if (wr_tima) begin
            tima  <= wdata;
            state <= TIM_RUN;
          end else if (cnt == '0) begin
            tima  <= tma_next;
            irq   <= 1'b1;
            state <= TIM_RELOAD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        TIM_RELOAD: begin
          state <= TIM_RUN;
          if (tap_fall) begin
            if (reload_base == 8'hFF) begin
              tima  <= 8'h00;
              cnt   <= CW'(RELOAD_DELAY - 1);
              state <= TIM_OVF;
            end else begin
              tima <= reload_base + 8'd1;
            end
          end else begin
            tima <= reload_base;
          end
        end
        default: state <= TIM_RUN;
      endcase
    end
  end

  always_comb begin
    rdata = 8'h00;
    case (sel)
      TIMER_DIV:  rdata = counter[15:8];
      TIMER_TIMA: rdata = tima;
      TIMER_TMA:  rdata = tma;
      TIMER_TAC:  rdata = {5'b11111, tac};
      default:    rdata = 8'h00;
    endcase
  end

  assign apu_div_bit = double_speed ? counter[13] : counter[12];

endmodule
